// File: rtl/mux_scan_pkg.sv
// Shared widths and FSM encoding for the mux scan sequencer.
// Imported by the scan controller, its channel finder and the stream interface.
package mux_scan_pkg;
    localparam int NCH    = 8;
    localparam int SEL_W  = 3;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    typedef enum logic {
        S_IDLE,
        S_SETTLE
    } state_t;
endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Tagged-sample output stream: one (channel, data) beat per valid/ready transfer.
// Master holds data and channel stable while valid is high and ready is low.
interface mux_scan_ctrl_if;
    import mux_scan_pkg::*;

    logic [DATA_W-1:0] out_data;
    logic [SEL_W-1:0]  out_ch;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_ch, output out_valid, input out_ready);
    modport slave  (input out_data, input out_ch, input out_valid, output out_ready);
endinterface

// File: rtl/mux.sv
// 8-to-1, 8-bit combinational multiplexer sampled by the scan controller.
// Zero latency, no flow control.
module mux
    import mux_scan_pkg::*;
(
    input  logic [DATA_W-1:0] i0,
    input  logic [DATA_W-1:0] i1,
    input  logic [DATA_W-1:0] i2,
    input  logic [DATA_W-1:0] i3,
    input  logic [DATA_W-1:0] i4,
    input  logic [DATA_W-1:0] i5,
    input  logic [DATA_W-1:0] i6,
    input  logic [DATA_W-1:0] i7,
    input  logic [SEL_W-1:0]  s,
    output logic [DATA_W-1:0] y
);
    always_comb begin
        case (s)
            3'd0:    y = i0;
            3'd1:    y = i1;
            3'd2:    y = i2;
            3'd3:    y = i3;
            3'd4:    y = i4;
            3'd5:    y = i5;
            3'd6:    y = i6;
            default: y = i7;
        endcase
    end
endmodule

// File: rtl/mux_scan_next.sv
// Priority finder: next enabled channel above the current one (wrapping), and the lowest enabled channel.
// Purely combinational; is_last_o flags that nothing enabled lies above the current channel.
module mux_scan_next
    import mux_scan_pkg::*;
(
    input  logic [SEL_W-1:0] cur_i,
    input  logic [NCH-1:0]   mask_i,
    output logic [SEL_W-1:0] next_o,
    output logic             is_last_o,
    output logic [SEL_W-1:0] lowest_o
);
    always_comb begin
        lowest_o  = '0;
        is_last_o = 1'b1;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_i[i]) lowest_o = SEL_W'(i);
        end
        // Descending scan leaves the smallest enabled channel above cur_i; wrap to lowest otherwise.
        next_o = lowest_o;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_i[i] && (i > int'(cur_i))) begin
                next_o    = SEL_W'(i);
                is_last_o = 1'b0;
            end
        end
    end
endmodule

// File: rtl/mux_scan_ctrl.sv
// Drives the mux select over a masked channel set, samples y after DWELL cycles, emits tagged beats.
// First beat DWELL cycles after start; a full output slot stalls the dwell counter at zero.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              mode,
    input  logic [NCH-1:0]    chan_mask,
    output logic [SEL_W-1:0]  s,
    input  logic [DATA_W-1:0] y,
    mux_scan_ctrl_if.master   out_if,
    output logic              busy,
    output logic              done
);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  s_q, s_d;
    logic [NCH-1:0]    mask_q, mask_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;

    logic [NCH-1:0]    fnd_mask;
    logic [SEL_W-1:0]  nxt_ch, low_ch;
    logic              is_last;
    logic              slot_free;

    // In IDLE the finder looks at the live mask so the first channel is ready at start.
    assign fnd_mask  = (state_q == S_IDLE) ? chan_mask : mask_q;
    assign slot_free = !valid_q || out_if.out_ready;

    mux_scan_next u_next (
        .cur_i     (s_q),
        .mask_i    (fnd_mask),
        .next_o    (nxt_ch),
        .is_last_o (is_last),
        .lowest_o  (low_ch)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        mask_d  = mask_q;
        mode_d  = mode_q;
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        done_d  = 1'b0;

        if (valid_q && out_if.out_ready) valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    if (chan_mask != '0) begin
                        mask_d  = chan_mask;
                        mode_d  = mode;
                        s_d     = low_ch;
                        cnt_d   = RELOAD;
                        state_d = S_SETTLE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (stop) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (slot_free) begin
                    data_d  = y;
                    ch_d    = s_q;
                    valid_d = 1'b1;
                    if (is_last && !mode_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        s_d   = nxt_ch;
                        cnt_d = RELOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            mask_q  <= '0;
            mode_q  <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign s                = s_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_ch    = ch_q;
    assign out_if.out_valid = valid_q;
    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;
endmodule
